voice_amp_scheduler: RTL
========================

VOICE_AMP_SCHEDULER -- requirements
Module: voice_amp_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of voices sharing one Amplifier instance.
REQ-002 Parameter AMP_LATENCY, default 2: Sys_clk cycles from operands driven with Amp_ce high to valid Amp_out.
REQ-003 Parameter OUT_SHIFT, default 12: arithmetic right shift applied to the mix accumulator before saturation.
REQ-004 Sys_clk  input  1  single system clock; all logic is rising-edge.
REQ-005 Sched_rst  input  1  synchronous, active-high reset.
REQ-006 Frame_strobe  input  1  one-cycle pulse requesting one mixed sample (AC97 frame rate).
REQ-007 Voice_en  input  NUM_VOICES  per-voice enable mask; bit i enables voice i.
REQ-008 Env_bus  input  32*NUM_VOICES  voice i envelope in bits [32i+31:32i].
REQ-009 Osc_bus  input  32*NUM_VOICES  voice i oscillator in bits [32i+31:32i].
REQ-010 Amp_out_i  input  32  shared Amplifier result, signed two's complement.
REQ-011 Amp_ce_o  output  1  Amplifier clock enable.
REQ-012 Amp_rst_o  output  1  Amplifier reset, equal to Sched_rst combinationally.
REQ-013 Amplitude_o / Oscillator_o  output  32 each  operands to the Amplifier for the current voice.
REQ-014 Sample_out  output  20  signed mixed sample for the AC97 slot.
REQ-015 Sample_valid  output  1  one-cycle pulse: Sample_out updated.
REQ-016 Busy  output  1  high whenever FSM is not IDLE.
REQ-017 Overrun  output  1  sticky: Frame_strobe arrived while Busy.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, ACCUM, DONE.
REQ-019 IDLE + Frame_strobe: latch Voice_en into mask register, clear 34-bit signed accumulator, next state ISSUE at lowest enabled voice, or DONE if mask is zero.
REQ-020 ISSUE (1 cycle): Amp_ce_o=1, Amplitude_o/Oscillator_o = selected voice slice; next WAIT.
REQ-021 WAIT (AMP_LATENCY cycles, counted by a down-counter): Amp_ce_o=1, operands held; next ACCUM.
REQ-022 ACCUM (1 cycle): accumulator += sign-extended Amp_out_i; Amp_ce_o=1; next ISSUE at next higher enabled voice, else DONE.
REQ-023 Disabled voices SHALL be skipped with zero cycles spent and zero contribution.
REQ-024 DONE (1 cycle): Sample_out = saturate20(accumulator >>> OUT_SHIFT), clamped to [20'h80000, 20'h7FFFF]; Sample_valid=1 this cycle only; next IDLE.
REQ-025 Latency: with E enabled voices and strobe at cycle 0, Sample_valid SHALL be high at cycle 1+E*(AMP_LATENCY+2); E=0 gives cycle 1 with Sample_out=0.
REQ-026 Frame_strobe while Busy (including DONE) SHALL be ignored and SHALL set Overrun; Overrun clears only on reset.
REQ-027 Voice_en changes mid-frame SHALL NOT affect the current frame; Env_bus/Osc_bus are used live at each ISSUE/WAIT cycle.
REQ-028 In IDLE, Amp_ce_o=0 and Amplitude_o/Oscillator_o=0.
REQ-029 Sample_out SHALL hold its value between Sample_valid pulses.

Reset
REQ-030 Sched_rst high at a clock edge SHALL force IDLE, mask=0, accumulator=0, wait counter=0, Sample_out=0, Sample_valid=0, Busy=0, Overrun=0, Amp_ce_o=0, operands=0, from any state including mid-frame; no Sample_valid follows an aborted frame.
REQ-031 Frame_strobe coincident with Sched_rst SHALL be ignored.

Verification
REQ-032 Stub Amp_out=32'h0000_1000 for every voice, Voice_en=4'hF, one strobe -> Sample_valid at cycle 17, Sample_out=20'h00004, Amp_ce_o high cycles 1-16.
REQ-033 Voice_en=4'b0101, stub Amp_out=32'h0000_3000 -> only voices 0,2 issued (Amplitude_o matches slices 0,2), Sample_valid at cycle 9, Sample_out=20'h00006.
REQ-034 Stub Amp_out=32'h7FFF_FFFF, 4 voices -> Sample_out=20'h7FFFF; stub 32'h8000_0000 -> Sample_out=20'h80000.
REQ-035 Voice_en=0, strobe -> Sample_valid at cycle 1, Sample_out=0, Amp_ce_o never asserted.
REQ-036 Second strobe at cycle 5 of a 4-voice frame -> Overrun=1, single Sample_valid at cycle 17, Busy low at cycle 18.
REQ-037 Sched_rst at cycle 6 of a 4-voice frame -> all outputs 0 at cycle 7, no Sample_valid; next strobe produces a correct frame.

Source files
------------

// File: rtl/voice_amp_scheduler.sv
// Time-multiplexes one shared Amplifier across NUM_VOICES voices and
// mixes their outputs into one saturated 20-bit sample per frame.
module voice_amp_scheduler #(
    parameter int NUM_VOICES  = 4,
    parameter int AMP_LATENCY = 2,
    parameter int OUT_SHIFT   = 12
) (
    input  logic                    Sys_clk,
    input  logic                    Sched_rst,
    input  logic                    Frame_strobe,
    input  logic [NUM_VOICES-1:0]   Voice_en,
    input  logic [32*NUM_VOICES-1:0] Env_bus,
    input  logic [32*NUM_VOICES-1:0] Osc_bus,
    input  logic [31:0]             Amp_out_i,
    output logic                    Amp_ce_o,
    output logic                    Amp_rst_o,
    output logic [31:0]             Amplitude_o,
    output logic [31:0]             Oscillator_o,
    output logic [19:0]             Sample_out,
    output logic                    Sample_valid,
    output logic                    Busy,
    output logic                    Overrun
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = (AMP_LATENCY > 1) ? $clog2(AMP_LATENCY + 1) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, DONE} state_t;

    state_t                 state;
    logic [NUM_VOICES-1:0]  mask;
    logic [VW-1:0]          voice;
    logic [CW-1:0]          wait_cnt;
    logic signed [33:0]     acc;

    logic                   low_found;
    logic [VW-1:0]          low_voice;
    logic                   nxt_found;
    logic [VW-1:0]          nxt_voice;
    logic signed [33:0]     acc_sum;
    logic signed [33:0]     shifted;
    logic [19:0]            sat_out;

    assign Amp_rst_o = Sched_rst;

    // Operands follow the live buses while the amplifier is enabled.
    assign Amplitude_o  = Amp_ce_o ? Env_bus[32*int'(voice) +: 32] : '0;
    assign Oscillator_o = Amp_ce_o ? Osc_bus[32*int'(voice) +: 32] : '0;

    always_comb begin
        low_found = 1'b0;
        low_voice = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (Voice_en[i]) begin
                low_found = 1'b1;
                low_voice = VW'(i);
            end
        end
        nxt_found = 1'b0;
        nxt_voice = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(voice))) begin
                nxt_found = 1'b1;
                nxt_voice = VW'(i);
            end
        end
    end

    always_comb begin
        acc_sum = acc + {{2{Amp_out_i[31]}}, Amp_out_i};
        shifted = acc_sum >>> OUT_SHIFT;
        if (shifted > 34'sd524287)
            sat_out = 20'h7FFFF;
        else if (shifted < -34'sd524288)
            sat_out = 20'h80000;
        else
            sat_out = shifted[19:0];
    end

    always_ff @(posedge Sys_clk) begin
        if (Sched_rst) begin
            state        <= IDLE;
            mask         <= '0;
            voice        <= '0;
            wait_cnt     <= '0;
            acc          <= '0;
            Amp_ce_o     <= 1'b0;
            Sample_out   <= '0;
            Sample_valid <= 1'b0;
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            Sample_valid <= 1'b0;
            if (Frame_strobe && state != IDLE)
                Overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (Frame_strobe) begin
                        mask <= Voice_en;
                        acc  <= '0;
                        Busy <= 1'b1;
                        if (low_found) begin
                            state    <= ISSUE;
                            voice    <= low_voice;
                            Amp_ce_o <= 1'b1;
                        end else begin
                            state        <= DONE;
                            Sample_out   <= '0;
                            Sample_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= CW'(AMP_LATENCY - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0)
                        state <= ACCUM;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                ACCUM: begin
                    acc <= acc_sum;
                    if (nxt_found) begin
                        state <= ISSUE;
                        voice <= nxt_voice;
                    end else begin
                        state        <= DONE;
                        Amp_ce_o     <= 1'b0;
                        Sample_out   <= sat_out;
                        Sample_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
